// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory handshake
module multicycle_control #(
  parameter int ALU_CTRL_W    = 3,
  parameter bit ENABLE_ADDI   = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  IorD,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  PCEn,
  output logic [1:0]            PCSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  RegDst,
  output logic                  MemToReg,
  output logic                  RegWrite,
  output logic                  InstrDone,
  output logic                  Illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  logic       w_ready;
  logic       w_funct_ok;
  logic [2:0] w_alu_funct;
  logic [2:0] w_alu;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcen;
  logic       w_regwrite;
  logic       w_done;
  logic       w_illegal;

  // With the handshake disabled the memory is assumed to finish every access in one cycle
  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Legal R-type function codes, judged on the live funct during DECODE
  always_comb begin
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
      default:                                               w_funct_ok = 1'b0;
    endcase
  end

  // ALU operation for R-type execute, taken from the captured funct
  always_comb begin
    case (r_funct)
      6'b100000: w_alu_funct = ALU_ADD;
      6'b100010: w_alu_funct = ALU_SUB;
      6'b100100: w_alu_funct = ALU_AND;
      6'b100101: w_alu_funct = ALU_OR;
      6'b101010: w_alu_funct = ALU_SLT;
      default:   w_alu_funct = ALU_ADD;
    endcase
  end

  // State register plus the opcode/funct snapshot taken at the end of DECODE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_op    <= 6'd0;
      r_funct <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= opcode;
        r_funct <= funct;
      end
    end
  end

  // Next-state sequencing; DECODE dispatches on the live inputs, later states on the snapshot
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      w_next = w_funct_ok ? S_EXEC : S_ILLEGAL;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI:       w_next = ENABLE_ADDI ? S_ADDIEX : S_ILLEGAL;
          default:       w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_ILLEGAL: w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls; strobes are computed here and masked by reset below
  always_comb begin
    IorD       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b01;
    w_alu      = ALU_ADD;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    w_regwrite = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = w_ready;
        w_pcen    = w_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        ALUSrcB   = 2'b00;
        IorD      = 1'b1;
        w_memread = 1'b1;
      end
      S_MEMWB: begin
        ALUSrcB    = 2'b00;
        MemToReg   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        ALUSrcB    = 2'b00;
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = w_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        w_alu   = w_alu_funct;
      end
      S_ALUWB: begin
        ALUSrcB    = 2'b00;
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        w_alu   = ALU_SUB;
        PCSrc   = 2'b01;
        w_pcen  = (r_op == OP_BNE) ? ~Zero : Zero;
        w_done  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        ALUSrcB    = 2'b00;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        ALUSrcB = 2'b00;
        PCSrc   = 2'b10;
        w_pcen  = 1'b1;
        w_done  = 1'b1;
      end
      S_ILLEGAL: begin
        ALUSrcB   = 2'b00;
        w_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // ALUControl is zero-extended from the 3-bit operation code
  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = w_alu;
  end

  // Every write enable and strobe is held off while reset is asserted
  assign MemRead   = w_memread  & reset_n;
  assign MemWrite  = w_memwrite & reset_n;
  assign IRWrite   = w_irwrite  & reset_n;
  assign PCEn      = w_pcen     & reset_n;
  assign RegWrite  = w_regwrite & reset_n;
  assign InstrDone = w_done     & reset_n;
  assign Illegal   = w_illegal  & reset_n;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table, directed and random checks for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       Zero, mem_ready;

  logic       IorD, MemRead, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemToReg, RegWrite, InstrDone, Illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;

  logic       IorD2, MemRead2, MemWrite2, IRWrite2, PCEn2, ALUSrcA2, RegDst2, MemToReg2, RegWrite2, InstrDone2, Illegal2;
  logic [1:0] PCSrc2, ALUSrcB2;
  logic [2:0] ALUControl2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  multicycle_control #(.ALU_CTRL_W(3), .ENABLE_ADDI(1'b0), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .PCEn(PCEn2), .PCSrc(PCSrc2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUControl(ALUControl2), .RegDst(RegDst2), .MemToReg(MemToReg2),
    .RegWrite(RegWrite2), .InstrDone(InstrDone2), .Illegal(Illegal2)
  );

  typedef struct {
    int         cycles, n_rw, n_mw, n_mr, n_iord, n_pcen, n_ir, n_done, n_ill;
    logic [2:0] alu;
    logic [1:0] pcsrc;
    logic       rd, m2r, zero_br;
    bit         timeout;
  } st_t;

  typedef struct {
    logic [5:0] op, fn;
    int         cyc, rw, done, ill;
    logic [2:0] alu;
  } tv_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a;
  endfunction

  // 0 R, 1 lw, 2 sw, 3 beq, 4 bne, 5 j, 6 addi, 7 illegal
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn, input bit addi_en);
    case (op)
      6'h00:   return funct_legal(fn) ? 0 : 7;
      6'h23:   return 1;
      6'h2b:   return 2;
      6'h04:   return 3;
      6'h05:   return 4;
      6'h02:   return 5;
      6'h08:   return addi_en ? 6 : 7;
      default: return 7;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected whole-instruction totals from the instruction class and the wait-state counts
  function automatic st_t model(input int k, input logic [5:0] fn, input int fw, input int mw, input logic z);
    st_t e = '{default: 0};
    e.n_mr = fw + 1; e.n_pcen = 1; e.n_ir = 1; e.n_done = 1; e.alu = 3'b010;
    case (k)
      0: begin e.cycles = 4 + fw; e.n_rw = 1; e.rd = 1'b1; e.alu = alu_of(fn); end
      1: begin e.cycles = 5 + fw + mw; e.n_rw = 1; e.m2r = 1'b1; e.n_mr += mw + 1; e.n_iord = mw + 1; end
      2: begin e.cycles = 4 + fw + mw; e.n_mw = mw + 1; e.n_iord = mw + 1; end
      3: begin e.cycles = 3 + fw; e.n_pcen += int'(z); e.alu = 3'b110; e.pcsrc = 2'b01; end
      4: begin e.cycles = 3 + fw; e.n_pcen += int'(!z); e.alu = 3'b110; e.pcsrc = 2'b01; end
      5: begin e.cycles = 3 + fw; e.n_pcen += 1; e.pcsrc = 2'b10; end
      6: begin e.cycles = 4 + fw; e.n_rw = 1; end
      default: begin e.cycles = 3 + fw; e.n_done = 0; e.n_ill = 1; end
    endcase
    return e;
  endfunction

  // Entered just after the edge that starts FETCH; returns just after the edge that starts the next FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, output st_t s);
    int  k   = kind_of(op, fn, 1'b1);
    bit  mem = (k == 1) || (k == 2);
    int  mst = fw + 3;
    bit  ended = 1'b0;
    s = '{default: 0};
    for (int c = 0; c < 80; c++) begin
      if (c < fw) mem_ready = 1'b0;
      else if (c == fw) mem_ready = 1'b1;
      else if (mem && c >= mst && c < mst + mw) mem_ready = 1'b0;
      else if (mem && c == mst + mw) mem_ready = 1'b1;
      else mem_ready = 1'($urandom % 2);
      if (c <= fw + 1) begin opcode = op; funct = fn; end
      else begin opcode = 6'($urandom); funct = 6'($urandom); end
      Zero = 1'($urandom % 2);
      if (c == fw + 2) s.zero_br = Zero;
      @(negedge clk);
      s.cycles = c + 1;
      s.n_rw += int'(RegWrite); s.n_mw += int'(MemWrite); s.n_mr += int'(MemRead);
      s.n_iord += int'(IorD); s.n_pcen += int'(PCEn); s.n_ir += int'(IRWrite);
      s.n_done += int'(InstrDone); s.n_ill += int'(Illegal);
      if (c == fw + 2) s.alu = ALUControl;
      if (RegWrite) begin s.rd = RegDst; s.m2r = MemToReg; end
      if (InstrDone || Illegal) begin s.pcsrc = PCSrc; ended = 1'b1; end
      @(posedge clk); #1;
      if (ended) break;
    end
    s.timeout = !ended;
  endtask

  tv_t  tv [13];
  st_t  s, e;
  logic [5:0] rop, rfn;
  int   fw, mw, r;

  initial begin
    tv[0]  = '{6'h00, 6'h20, 4, 1, 1, 0, 3'b010};
    tv[1]  = '{6'h00, 6'h22, 4, 1, 1, 0, 3'b110};
    tv[2]  = '{6'h00, 6'h24, 4, 1, 1, 0, 3'b000};
    tv[3]  = '{6'h00, 6'h25, 4, 1, 1, 0, 3'b001};
    tv[4]  = '{6'h00, 6'h2a, 4, 1, 1, 0, 3'b111};
    tv[5]  = '{6'h23, 6'h00, 5, 1, 1, 0, 3'b010};
    tv[6]  = '{6'h2b, 6'h00, 4, 0, 1, 0, 3'b010};
    tv[7]  = '{6'h04, 6'h00, 3, 0, 1, 0, 3'b110};
    tv[8]  = '{6'h05, 6'h00, 3, 0, 1, 0, 3'b110};
    tv[9]  = '{6'h02, 6'h00, 3, 0, 1, 0, 3'b010};
    tv[10] = '{6'h08, 6'h00, 4, 1, 1, 0, 3'b010};
    tv[11] = '{6'h3f, 6'h00, 3, 0, 0, 1, 3'b010};
    tv[12] = '{6'h00, 6'h07, 3, 0, 0, 1, 3'b010};

    reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_memread", int'(MemRead), 0);
    check("rst_irwrite", int'(IRWrite), 0);
    check("rst_pcen", int'(PCEn), 0);
    check("rst_done", int'(InstrDone), 0);
    check("rst_iord", int'(IorD), 0);
    check("rst_alusrcb", int'(ALUSrcB), 1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_instr(tv[i].op, tv[i].fn, 0, 0, s);
      check($sformatf("tv%0d_cycles", i), s.cycles, tv[i].cyc);
      check($sformatf("tv%0d_regwrite", i), s.n_rw, tv[i].rw);
      check($sformatf("tv%0d_done", i), s.n_done, tv[i].done);
      check($sformatf("tv%0d_illegal", i), s.n_ill, tv[i].ill);
      check($sformatf("tv%0d_alu", i), int'(s.alu), int'(tv[i].alu));
    end

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom % 10);
      rfn = 6'h00;
      case (r)
        0, 1, 2: begin
          rop = 6'h00;
          case ($urandom % 6)
            0: rfn = 6'h20; 1: rfn = 6'h22; 2: rfn = 6'h24; 3: rfn = 6'h25; 4: rfn = 6'h2a;
            default: rfn = 6'($urandom);
          endcase
        end
        3: rop = 6'h23;
        4: rop = 6'h2b;
        5: rop = 6'h04;
        6: rop = 6'h05;
        7: rop = 6'h02;
        8: rop = 6'h08;
        default: rop = 6'($urandom);
      endcase
      fw = int'($urandom % 3);
      mw = int'($urandom % 3);
      run_instr(rop, rfn, fw, mw, s);
      e = model(kind_of(rop, rfn, 1'b1), rfn, fw, mw, s.zero_br);
      check("rnd_timeout", int'(s.timeout), 0);
      check("rnd_cycles", s.cycles, e.cycles);
      check("rnd_regwrite", s.n_rw, e.n_rw);
      check("rnd_memwrite", s.n_mw, e.n_mw);
      check("rnd_memread", s.n_mr, e.n_mr);
      check("rnd_iord", s.n_iord, e.n_iord);
      check("rnd_pcen", s.n_pcen, e.n_pcen);
      check("rnd_irwrite", s.n_ir, e.n_ir);
      check("rnd_done", s.n_done, e.n_done);
      check("rnd_illegal", s.n_ill, e.n_ill);
      check("rnd_alu", int'(s.alu), int'(e.alu));
      check("rnd_pcsrc", int'(s.pcsrc), int'(e.pcsrc));
      if (e.n_rw != 0) begin
        check("rnd_regdst", int'(s.rd), int'(e.rd));
        check("rnd_memtoreg", int'(s.m2r), int'(e.m2r));
      end
    end

    run_instr(6'h23, 6'h00, 0, 2, s);
    check("lw_stall_cycles", s.cycles, 7);
    check("lw_stall_memread", s.n_mr, 4);
    check("lw_stall_iord", s.n_iord, 3);
    check("lw_stall_memtoreg", int'(s.m2r), 1);

    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr_memwrite", int'(MemWrite), 1);
    check("memwr_iord", int'(IorD), 1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_memwrite", int'(MemWrite), 0);
    check("abort_iord", int'(IorD), 0);
    check("abort_memread", int'(MemRead), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_instr(6'h00, 6'h20, 0, 0, s);
    check("restart_cycles", s.cycles, 4);
    check("restart_done", s.n_done, 1);

    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; opcode = 6'h08; funct = 6'h00; mem_ready = 1'b0;
    @(negedge clk);
    check("nohs_irwrite", int'(IRWrite2), 1);
    check("stall_irwrite", int'(IRWrite), 0);
    check("stall_memread", int'(MemRead), 1);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("noaddi_illegal", int'(Illegal2), 1);
    check("noaddi_done", int'(InstrDone2), 0);
    check("noaddi_regwrite", int'(RegWrite2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
